// File: rtl/cc_pkg.sv
// Shared types and constants for the cache-controller line-refill engine:
// address field split, AXI encodings used on the memory AR channel, FSM states.
package cc_pkg;
    localparam int TAG_W      = 18;
    localparam int IDX_W      = 8;
    localparam int OFF_W      = 6;
    localparam int LINE_WORDS = 8;
    localparam int WPTR_W     = 3;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] index;
        logic [OFF_W-1:0] offset;
    } cc_addr_t;

    localparam logic [1:0] BURST_WRAP = 2'b10;
    localparam logic [2:0] SIZE_8B    = 3'b011;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [3:0] BURST_LEN8 = 4'd7;

    typedef enum logic [1:0] {
        IDLE,
        AR,
        DATA,
        WRITE
    } cc_state_t;
endpackage

// File: rtl/cc_line_buf.sv
// 8-word line assembly register. Words are written through a wrap pointer so a
// critical-word-first burst lands in natural line order; the line is read flat.
module cc_line_buf
    import cc_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [WPTR_W-1:0]            wr_ptr,
    input  logic [DATA_W-1:0]            wr_data,
    output logic [LINE_WORDS*DATA_W-1:0] line
);
    logic [LINE_WORDS-1:0][DATA_W-1:0] words;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            words <= '0;
        end else if (wr_en) begin
            for (int w = 0; w < LINE_WORDS; w++) begin
                if (wr_ptr == WPTR_W'(w))
                    words[w] <= wr_data;
            end
        end
    end

    assign line = words;
endmodule

// File: rtl/cc_refill_unit.sv
// Line-refill engine: one 8-beat WRAP read per miss, beats forwarded to the INCT
// R channel and assembled into a line written to SRAM. Optional protocol/response
// checking is enabled with the CC_REFILL_PROTO_CHK_EN macro.
module cc_refill_unit
    import cc_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       miss_valid_i,
    output logic                       miss_ready_o,
    input  logic [ADDR_WIDTH-1:0]      miss_addr_i,
    input  logic [ID_WIDTH-1:0]        miss_id_i,
    input  logic                       miss_way_i,
    output logic [ID_WIDTH-1:0]        mem_arid_o,
    output logic [ADDR_WIDTH-1:0]      mem_araddr_o,
    output logic [3:0]                 mem_arlen_o,
    output logic [2:0]                 mem_arsize_o,
    output logic [1:0]                 mem_arburst_o,
    output logic                       mem_arvalid_o,
    input  logic                       mem_arready_i,
    input  logic [ID_WIDTH-1:0]        mem_rid_i,
    input  logic [DATA_WIDTH-1:0]      mem_rdata_i,
    input  logic [1:0]                 mem_rresp_i,
    input  logic                       mem_rlast_i,
    input  logic                       mem_rvalid_i,
    output logic                       mem_rready_o,
    output logic [ID_WIDTH-1:0]        fwd_rid_o,
    output logic [DATA_WIDTH-1:0]      fwd_rdata_o,
    output logic [1:0]                 fwd_rresp_o,
    output logic                       fwd_rlast_o,
    output logic                       fwd_rvalid_o,
    input  logic                       fwd_rready_i,
    output logic                       wren_o,
    output logic [IDX_W-1:0]           waddr_o,
    output logic                       wway_o,
    output logic [TAG_W:0]             wdata_tag_o,
    output logic [LINE_WORDS*DATA_WIDTH-1:0] wdata_data_o,
    output logic                       busy_o,
    output logic                       err_o
);
    cc_state_t           state, state_nxt;
    cc_addr_t            addr_q;
    logic [ID_WIDTH-1:0] id_q;
    logic                way_q;
    logic [WPTR_W-1:0]   beat_q;

    logic miss_hs, r_hs, line_done, line_bad, buf_wr;

    assign miss_hs = (state == IDLE) && miss_valid_i;
    assign r_hs    = (state == DATA) && mem_rvalid_i && fwd_rready_i;

`ifdef CC_REFILL_PROTO_CHK_EN
    // Beats past the eighth are drained until rlast but never reach the buffer.
    logic extra_q, bad_q, err_q, beat_bad;

    assign beat_bad  = (mem_rresp_i != RESP_OKAY) || (mem_rid_i != id_q) ||
                       (mem_rlast_i != ((beat_q == 3'd7) && !extra_q));
    assign line_done = r_hs && mem_rlast_i;
    assign line_bad  = bad_q || beat_bad;
    assign buf_wr    = r_hs && !extra_q;
    assign err_o     = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            extra_q <= 1'b0;
            bad_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (miss_hs) begin
                extra_q <= 1'b0;
                bad_q   <= 1'b0;
            end else if (r_hs) begin
                if (beat_q == 3'd7 && !mem_rlast_i)
                    extra_q <= 1'b1;
                if (beat_bad)
                    bad_q <= 1'b1;
            end
            if (r_hs && beat_bad)
                err_q <= 1'b1;
        end
    end
`else
    logic unused_rid;

    assign unused_rid = ^mem_rid_i;
    assign line_done  = r_hs && (beat_q == 3'd7);
    assign line_bad   = 1'b0;
    assign buf_wr     = r_hs;
    assign err_o      = 1'b0;
`endif

    logic unused_off;
    assign unused_off = ^addr_q.offset[2:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            addr_q <= '0;
            id_q   <= '0;
            way_q  <= 1'b0;
            beat_q <= '0;
        end else begin
            state <= state_nxt;
            if (miss_hs) begin
                addr_q <= cc_addr_t'(miss_addr_i);
                id_q   <= miss_id_i;
                way_q  <= miss_way_i;
                beat_q <= '0;
            end else if (r_hs) begin
                beat_q <= beat_q + 3'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (miss_valid_i)  state_nxt = AR;
            AR:    if (mem_arready_i) state_nxt = DATA;
            DATA:  if (line_done)     state_nxt = line_bad ? IDLE : WRITE;
            WRITE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // AR fields come straight from registers latched at acceptance, so they
    // cannot move while arvalid waits for arready.
    assign miss_ready_o  = (state == IDLE);
    assign busy_o        = (state != IDLE);
    assign mem_arvalid_o = (state == AR);
    assign mem_arid_o    = id_q;
    assign mem_araddr_o  = ADDR_WIDTH'({addr_q.tag, addr_q.index, addr_q.offset[5:3], 3'b000});
    assign mem_arlen_o   = BURST_LEN8;
    assign mem_arsize_o  = SIZE_8B;
    assign mem_arburst_o = BURST_WRAP;

    assign fwd_rvalid_o  = (state == DATA) && mem_rvalid_i;
    assign mem_rready_o  = (state == DATA) && fwd_rready_i;
    assign fwd_rid_o     = id_q;
    assign fwd_rdata_o   = mem_rdata_i;
    assign fwd_rresp_o   = mem_rresp_i;
    assign fwd_rlast_o   = mem_rlast_i;

    // Valid bit tracks the write strobe so the tag word reads 0 out of reset.
    assign wren_o      = (state == WRITE);
    assign waddr_o     = addr_q.index;
    assign wway_o      = way_q;
    assign wdata_tag_o = {wren_o, addr_q.tag};

    cc_line_buf #(.DATA_W(DATA_WIDTH)) u_line_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (buf_wr),
        .wr_ptr  (addr_q.offset[5:3] + beat_q),
        .wr_data (mem_rdata_i),
        .line    (wdata_data_o)
    );
endmodule

// File: tb/tb_cc_refill_unit.sv
// Directed and randomized refills checked against a line model built from the
// critical-word-first placement rule.
module tb_cc_refill_unit;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         miss_valid = 1'b0, miss_ready, miss_way = 1'b0;
    logic [31:0]  miss_addr = '0;
    logic [3:0]   miss_id = '0;
    logic [3:0]   arid, arlen;
    logic [31:0]  araddr;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid, arready = 1'b0;
    logic [3:0]   rid = '0;
    logic [63:0]  rdata = '0;
    logic [1:0]   rresp = '0;
    logic         rlast = 1'b0, rvalid = 1'b0, rready;
    logic [3:0]   f_rid;
    logic [63:0]  f_rdata;
    logic [1:0]   f_rresp;
    logic         f_rlast, f_rvalid, f_rready = 1'b1;
    logic         wren, wway, busy, err;
    logic [7:0]   waddr;
    logic [18:0]  wtag;
    logic [511:0] wdata;

    int checks = 0, failures = 0;
    logic exp_err = 1'b0;
    logic [511:0] dut_line;
    logic [63:0]  last_beats[8];

`ifdef CC_REFILL_PROTO_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    always #5 clk = ~clk;

    cc_refill_unit dut (
        .clk(clk), .rst_n(rst_n),
        .miss_valid_i(miss_valid), .miss_ready_o(miss_ready), .miss_addr_i(miss_addr),
        .miss_id_i(miss_id), .miss_way_i(miss_way),
        .mem_arid_o(arid), .mem_araddr_o(araddr), .mem_arlen_o(arlen), .mem_arsize_o(arsize),
        .mem_arburst_o(arburst), .mem_arvalid_o(arvalid), .mem_arready_i(arready),
        .mem_rid_i(rid), .mem_rdata_i(rdata), .mem_rresp_i(rresp), .mem_rlast_i(rlast),
        .mem_rvalid_i(rvalid), .mem_rready_o(rready),
        .fwd_rid_o(f_rid), .fwd_rdata_o(f_rdata), .fwd_rresp_o(f_rresp), .fwd_rlast_o(f_rlast),
        .fwd_rvalid_o(f_rvalid), .fwd_rready_i(f_rready),
        .wren_o(wren), .waddr_o(waddr), .wway_o(wway), .wdata_tag_o(wtag),
        .wdata_data_o(wdata), .busy_o(busy), .err_o(err)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete refill. A negative bp_beat / err_beat disables that feature.
    task automatic do_refill(input logic [31:0] a, input logic [3:0] id, input logic way,
                             input int ar_delay, input int bp_beat, input int bp_len,
                             input int err_beat, input logic [1:0] err_resp,
                             input bit hold_next, input logic [31:0] na,
                             input logic [3:0] nid, input logic nway);
        logic [511:0] exp_line;
        int crit;
        bit bad;
        crit = int'(a[5:3]);
        bad  = CHK && (err_beat >= 0);
        exp_line = '0;

        miss_valid = 1'b1; miss_addr = a; miss_id = id; miss_way = way;
        #1;
        chk("miss_ready_idle", miss_ready, 1'b1);
        step();
        if (hold_next) begin
            miss_addr = na; miss_id = nid; miss_way = nway;
        end else begin
            miss_valid = 1'b0;
        end
        #1;
        chk("miss_ready_busy", miss_ready, 1'b0);
        chk("busy", busy, 1'b1);

        for (int c = 0; c <= ar_delay; c++) begin
            arready = (c == ar_delay);
            #1;
            chk("arvalid", arvalid, 1'b1);
            chk("araddr", araddr, {a[31:3], 3'b000});
            chk("arlen", arlen, 4'd7);
            chk("arsize", arsize, 3'd3);
            chk("arburst", arburst, 2'b10);
            chk("arid", arid, id);
            chk("rready_in_ar", rready, 1'b0);
            step();
        end
        arready = 1'b0;

        for (int k = 0; k < 8; k++) begin
            last_beats[k] = {$urandom, $urandom};
            rvalid = 1'b1; rdata = last_beats[k]; rid = id;
            rresp  = (k == err_beat) ? err_resp : 2'b00;
            rlast  = (k == 7);
            if (k == bp_beat) begin
                for (int s = 0; s < bp_len; s++) begin
                    f_rready = 1'b0;
                    #1;
                    chk("bp_rready", rready, 1'b0);
                    chk("bp_fwd_rvalid", f_rvalid, 1'b1);
                    step();
                end
            end
            f_rready = 1'b1;
            #1;
            chk("rready", rready, 1'b1);
            chk("fwd_rvalid", f_rvalid, 1'b1);
            chk("fwd_rdata", f_rdata, last_beats[k]);
            chk("fwd_rid", f_rid, id);
            chk("fwd_rresp", f_rresp, rresp);
            chk("fwd_rlast", f_rlast, (k == 7));
            chk("wren_in_data", wren, 1'b0);
            exp_line[((crit + k) % 8) * 64 +: 64] = last_beats[k];
            step();
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        if (bad) exp_err = 1'b1;
        #1;
        if (!bad) begin
            chk("wren", wren, 1'b1);
            chk("waddr", waddr, a[13:6]);
            chk("wway", wway, way);
            chk("wtag", wtag, {1'b1, a[31:14]});
            chk("wdata", wdata, exp_line);
            chk("miss_ready_write", miss_ready, 1'b0);
            chk("rready_in_write", rready, 1'b0);
            dut_line = wdata;
            step();
        end
        chk("wren_done", wren, 1'b0);
        chk("miss_ready_done", miss_ready, 1'b1);
        chk("err", err, exp_err);
    endtask

    initial begin
        step(); step();
        // Reset state
        chk("rst_miss_ready", miss_ready, 1'b1);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_fwd_rvalid", f_rvalid, 1'b0);
        chk("rst_wren", wren, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_wdata", wdata, 512'h0);
        chk("rst_wtag", wtag, 19'h0);
        rst_n = 1'b1;
        step();

        // Basic refill: critical word 7 first
        do_refill(32'h0000_5238, 4'd3, 1'b1, 0, -1, 0, -1, 2'b00, 1'b0, '0, '0, 1'b0);
        chk("basic_word7_beat0", dut_line[7*64 +: 64], last_beats[0]);
        chk("basic_word0_beat1", dut_line[0 +: 64], last_beats[1]);

        // Back-pressure at beat 4 for 3 cycles
        do_refill(32'h1234_5690, 4'd9, 1'b0, 0, 4, 3, -1, 2'b00, 1'b0, '0, '0, 1'b0);

        // AR stall of 5 cycles
        do_refill(32'hABCD_0008, 4'd1, 1'b1, 5, -1, 0, -1, 2'b00, 1'b0, '0, '0, 1'b0);

        // Back-to-back: second miss held through the first refill
        do_refill(32'h0000_7FC0, 4'd2, 1'b0, 1, -1, 0, -1, 2'b00, 1'b1,
                  32'h0040_0418, 4'd6, 1'b1);
        do_refill(32'h0040_0418, 4'd6, 1'b1, 0, -1, 0, -1, 2'b00, 1'b0, '0, '0, 1'b0);

        // Randomized refills
        for (int i = 0; i < 6; i++) begin
            do_refill($urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 2)), -1, 2'b00, 1'b0, '0, '0, 1'b0);
        end

        // Reset during beat 3
        miss_valid = 1'b1; miss_addr = 32'h0000_1240; miss_id = 4'd5; miss_way = 1'b0;
        step();
        miss_valid = 1'b0; arready = 1'b1;
        step();
        arready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rvalid = 1'b1; rdata = {$urandom, $urandom}; rid = 4'd5; rlast = 1'b0;
            step();
        end
        rvalid = 1'b1; rst_n = 1'b0;
        step();
        chk("mid_rst_miss_ready", miss_ready, 1'b1);
        chk("mid_rst_arvalid", arvalid, 1'b0);
        chk("mid_rst_rready", rready, 1'b0);
        chk("mid_rst_fwd_rvalid", f_rvalid, 1'b0);
        chk("mid_rst_wren", wren, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_err", err, 1'b0);
        chk("mid_rst_waddr", waddr, 8'h0);
        chk("mid_rst_araddr", araddr, 32'h0);
        chk("mid_rst_wdata", wdata, 512'h0);
        rst_n = 1'b1; rvalid = 1'b0; exp_err = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("post_rst_wren", wren, 1'b0);
        end
        do_refill(32'h0000_0040, 4'd4, 1'b0, 0, -1, 0, -1, 2'b00, 1'b0, '0, '0, 1'b0);

        // Error response on beat 4, then a clean refill (err stays sticky when checking)
        do_refill(32'h0F0F_3318, 4'd7, 1'b1, 0, -1, 0, 4, 2'b10, 1'b0, '0, '0, 1'b0);
        do_refill(32'h0000_2000, 4'd8, 1'b0, 0, -1, 0, -1, 2'b00, 1'b0, '0, '0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
